// File: rtl/snake_cell_map.sv
// Shadow map of the snake playfield: one colour per game cell, filled by snooping
// the pixel-write bus, and read back over a req/ack query port.
module snake_cell_map #(
    parameter int            XSCREEN = 160,
    parameter int            YSCREEN = 120,
    parameter int            CELL    = 10,
    parameter int            COLS    = 16,
    parameter int            ROWS    = 12,
    parameter int            CW      = 3,
    parameter logic [CW-1:0] BG      = 3'b000,
    parameter logic [CW-1:0] WALL    = 3'b111
) (
    input  logic          CLOCK_50,
    input  logic          Resetn,
    input  logic          plot,
    input  logic [7:0]    x,
    input  logic [6:0]    y,
    input  logic [CW-1:0] colour,
    input  logic          q_req,
    input  logic [7:0]    q_x,
    input  logic [6:0]    q_y,
    output logic          q_ready,
    output logic          busy,
    output logic          q_ack,
    output logic [CW-1:0] q_colour,
    output logic          q_hit
);

    localparam int         DEPTH   = COLS * ROWS;
    localparam logic [7:0] XS      = 8'(XSCREEN);
    localparam logic [6:0] YS      = 7'(YSCREEN);
    localparam logic [7:0] LAST    = 8'(DEPTH - 1);

    typedef enum logic [1:0] {CLEAR, IDLE, READ, RESP} state_t;

    state_t        state_q, state_d;
    logic [7:0]    clr_idx_q, clr_idx_d;
    logic [7:0]    qx_q, qx_d;
    logic [6:0]    qy_q, qy_d;
    logic          q_ack_q, q_ack_d;

    logic [CW-1:0] mem [0:DEPTH-1];
    logic [CW-1:0] rd_data_q;
    logic          oob_q;

    logic          wr_en;
    logic [7:0]    wr_addr;
    logic [CW-1:0] wr_data;
    logic          q_oob;
    logic [7:0]    rd_addr;

    function automatic logic [7:0] cell_addr(input logic [7:0] px, input logic [6:0] py);
        logic [7:0] col;
        logic [7:0] row;
        col = px / 8'(CELL);
        row = {1'b0, py / 7'(CELL)};
        return row * 8'(COLS) + col;
    endfunction

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        qx_d      = qx_q;
        qy_d      = qy_q;
        q_ack_d   = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_idx_d = clr_idx_q + 8'd1;
                if (clr_idx_q == LAST) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (q_req) begin
                    qx_d    = q_x;
                    qy_d    = q_y;
                    state_d = READ;
                end
            end
            READ: begin
                q_ack_d = 1'b1;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // The sweep owns the write port; the snooped bus only writes once the map is live.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = clr_idx_q;
        wr_data = BG;
        if (Resetn) begin
            if (state_q == CLEAR) begin
                wr_en = 1'b1;
            end else if (plot && (x < XS) && (y < YS)) begin
                wr_en   = 1'b1;
                wr_addr = cell_addr(x, y);
                wr_data = colour;
            end
        end
    end

    assign q_oob   = (qx_q >= XS) || (qy_q >= YS);
    assign rd_addr = q_oob ? 8'd0 : cell_addr(qx_q, qy_q);

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state_q   <= CLEAR;
            clr_idx_q <= 8'd0;
            qx_q      <= 8'd0;
            qy_q      <= 7'd0;
            q_ack_q   <= 1'b0;
            oob_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            qx_q      <= qx_d;
            qy_q      <= qy_d;
            q_ack_q   <= q_ack_d;
            if (state_q == READ) begin
                oob_q <= q_oob;
            end
        end
    end

    // Nonblocking read and write on the same edge give read-before-write.
    always_ff @(posedge CLOCK_50) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (!Resetn) begin
            rd_data_q <= '0;
        end else if (state_q == READ) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign busy     = (state_q == CLEAR);
    assign q_ready  = (state_q == IDLE);
    assign q_ack    = q_ack_q;
    assign q_colour = oob_q ? WALL : rd_data_q;
    assign q_hit    = (q_colour != BG);

endmodule

// File: tb/tb_snake_cell_map.sv
// Directed and randomized checks of snake_cell_map against a cell-level colour model.
module tb_snake_cell_map;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn   = 1'b0;
    logic       plot     = 1'b0;
    logic [7:0] x        = '0;
    logic [6:0] y        = '0;
    logic [2:0] colour   = '0;
    logic       q_req    = 1'b0;
    logic [7:0] q_x      = '0;
    logic [6:0] q_y      = '0;
    logic       q_ready, busy, q_ack, q_hit;
    logic [2:0] q_colour;

    int vectors = 0;
    int errors  = 0;
    logic [2:0] model [0:191];

    snake_cell_map dut (
        .CLOCK_50(CLOCK_50), .Resetn(Resetn), .plot(plot), .x(x), .y(y),
        .colour(colour), .q_req(q_req), .q_x(q_x), .q_y(q_y), .q_ready(q_ready),
        .busy(busy), .q_ack(q_ack), .q_colour(q_colour), .q_hit(q_hit)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] ref_colour(input int px, input int py);
        if (px >= 160 || py >= 120) return 3'b111;
        return model[(py / 10) * 16 + (px / 10)];
    endfunction

    // Drive one pixel write; model follows only on-screen writes.
    task automatic do_plot(input int px, input int py, input logic [2:0] c);
        @(negedge CLOCK_50);
        plot = 1'b1; x = 8'(px); y = 7'(py); colour = c;
        @(posedge CLOCK_50);
        if (px < 160 && py < 120) model[(py / 10) * 16 + (px / 10)] = c;
        @(negedge CLOCK_50);
        plot = 1'b0;
    endtask

    // Reset, then measure the clear sweep; optionally hammer q_req throughout it.
    task automatic do_reset(input bit req_during_clear);
        int n;
        int acks;
        @(negedge CLOCK_50);
        Resetn = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("reset_busy", int'(busy), 1);
        chk("reset_ready", int'(q_ready), 0);
        chk("reset_ack", int'(q_ack), 0);
        chk("reset_colour", int'(q_colour), 0);
        chk("reset_hit", int'(q_hit), 0);
        for (int i = 0; i < 192; i++) model[i] = 3'b000;
        Resetn = 1'b1;
        q_req = req_during_clear; q_x = 8'd20; q_y = 7'd20;
        n = 0; acks = 0;
        while (busy === 1'b1 && n < 1000) begin
            if (q_ack === 1'b1) acks++;
            n++;
            @(negedge CLOCK_50);
        end
        q_req = 1'b0;
        chk("clear_cycles", n, 192);
        chk("clear_acks", acks, 0);
        chk("ready_after_clear", int'(q_ready), 1);
        $display("reset sweep: busy cycles=%0d", n);
    endtask

    // One query. Optional plot on the READ edge, optional extra q_req during READ.
    task automatic do_query(input int qx, input int qy, input bit wr_in_read,
                            input logic [2:0] wc, input bit req_in_read);
        int n;
        logic [2:0] exp_c;
        @(negedge CLOCK_50);
        n = 0;
        while (q_ready !== 1'b1 && n < 100) begin
            n++;
            @(negedge CLOCK_50);
        end
        chk("query_ready_wait", int'(n < 100), 1);
        exp_c = ref_colour(qx, qy);
        q_req = 1'b1; q_x = 8'(qx); q_y = 7'(qy);
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        q_req = req_in_read;
        q_x = 8'd5; q_y = 7'd5;
        if (wr_in_read) begin
            plot = 1'b1; x = 8'(qx); y = 7'(qy); colour = wc;
        end
        chk("ack_in_read", int'(q_ack), 0);
        @(posedge CLOCK_50);
        if (wr_in_read && qx < 160 && qy < 120) model[(qy / 10) * 16 + (qx / 10)] = wc;
        @(negedge CLOCK_50);
        plot = 1'b0; q_req = 1'b0;
        chk("ack_pulse", int'(q_ack), 1);
        chk("q_colour", int'(q_colour), int'(exp_c));
        chk("q_hit", int'(q_hit), int'(exp_c != 3'b000));
        $display("query (%0d,%0d): colour=%0d hit=%0d exp=%0d", qx, qy, q_colour, q_hit, exp_c);
        @(negedge CLOCK_50);
        chk("ack_one_cycle", int'(q_ack), 0);
        @(negedge CLOCK_50);
        chk("no_extra_ack", int'(q_ack), 0);
        chk("colour_hold", int'(q_colour), int'(exp_c));
    endtask

    initial begin
        int n;
        // 1 + 5a: sweep with q_req held during CLEAR, then empty-map query.
        do_reset(1'b1);
        do_query(0, 0, 1'b0, 3'b000, 1'b0);

        // 2: fill one square, hit inside, miss next door.
        for (int i = 0; i < 100; i++) do_plot(30 + i % 10, 30 + i / 10, 3'b100);
        do_query(35, 33, 1'b0, 3'b000, 1'b0);
        do_query(45, 33, 1'b0, 3'b000, 1'b0);

        // 3: off-screen queries read as wall; off-screen plot changes nothing.
        do_query(160, 10, 1'b0, 3'b000, 1'b0);
        do_query(10, 120, 1'b0, 3'b000, 1'b0);
        do_plot(200, 5, 3'b011);
        for (int c = 0; c < 192; c++) do_query((c % 16) * 10 + 4, (c / 16) * 10 + 7, 1'b0, 3'b000, 1'b0);

        // 4: write on the READ edge returns old data; repeat sees new.
        do_query(50, 40, 1'b1, 3'b010, 1'b0);
        do_query(50, 40, 1'b0, 3'b000, 1'b0);

        // 5b: q_req during READ is dropped.
        do_query(37, 38, 1'b0, 3'b000, 1'b1);

        // Erase returns a cell to empty.
        for (int i = 0; i < 100; i++) do_plot(50 + i % 10, 40 + i / 10, 3'b000);
        do_query(55, 45, 1'b0, 3'b000, 1'b0);

        // Random plots and queries.
        for (int k = 0; k < 60; k++) begin
            repeat ($urandom_range(1, 4)) do_plot($urandom_range(0, 180), $urandom_range(0, 127), 3'($urandom));
            do_query($urandom_range(0, 175), $urandom_range(0, 127), 1'b0, 3'b000, 1'b0);
        end

        // 6: reset during READ aborts the query and clears the map.
        @(negedge CLOCK_50);
        q_req = 1'b1; q_x = 8'd35; q_y = 7'd33;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        q_req = 1'b0; Resetn = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLOCK_50);
            if (q_ack === 1'b1) n++;
        end
        chk("abort_no_ack", n, 0);
        do_reset(1'b0);
        do_query(35, 33, 1'b0, 3'b000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
